// File: rtl/sns_readout_if.sv
// rtl/sns_readout_if.sv - beat stream between the history readout and its consumer
interface sns_readout_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] out_data;
    logic [3:0]            out_index;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output out_data,
        output out_index,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_index,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sns_readout.sv
// rtl/sns_readout.sv - snapshots the shift-and-save history taps and streams them out
// Outputs are all registered, so the beat after a handshake is precomputed here.
module sns_readout #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] value0,
    input  logic [DATA_WIDTH-1:0] value1,
    input  logic [DATA_WIDTH-1:0] value2,
    input  logic [DATA_WIDTH-1:0] value3,
    input  logic [DATA_WIDTH-1:0] value4,
    input  logic [DATA_WIDTH-1:0] value5,
    input  logic [DATA_WIDTH-1:0] value6,
    input  logic [DATA_WIDTH-1:0] value7,
    input  logic [DATA_WIDTH-1:0] value8,
    input  logic [DATA_WIDTH-1:0] value9,
    input  logic                  start,
    input  logic                  order,
    input  logic                  abort,
    sns_readout_if.master         out,
    output logic                  busy,
    output logic                  done,
    output logic                  empty,
    output logic [3:0]            occupancy
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] taps   [DEPTH];
    logic [DATA_WIDTH-1:0] snap_q [DEPTH];
    logic [3:0]            occ_q, occ_d, snap_occ_q, snap_occ_d;
    logic                  order_q, order_d, snap_take;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            index_q, index_d, next_index;
    logic                  valid_q, valid_d, last_q, last_d;
    logic                  busy_q, busy_d, done_q, done_d, empty_q, empty_d;

    assign taps[0] = value0;
    assign taps[1] = value1;
    assign taps[2] = value2;
    assign taps[3] = value3;
    assign taps[4] = value4;
    assign taps[5] = value5;
    assign taps[6] = value6;
    assign taps[7] = value7;
    assign taps[8] = value8;
    assign taps[9] = value9;

    always_comb begin
        state_d    = state_q;
        snap_occ_d = snap_occ_q;
        order_d    = order_q;
        snap_take  = 1'b0;
        data_d     = data_q;
        index_d    = index_q;
        valid_d    = valid_q;
        last_d     = last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        empty_d    = 1'b0;
        next_index = order_q ? (index_q - 4'd1) : (index_q + 4'd1);
        occ_d      = (shift_en && (occ_q != 4'(DEPTH))) ? (occ_q + 4'd1) : occ_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_take  = 1'b1;
                    snap_occ_d = occ_q;
                    order_d    = order;
                    busy_d     = 1'b1;
                    if (occ_q == 4'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        empty_d = 1'b1;
                    end else begin
                        // First beat comes straight from the taps; the snapshot lands on this same edge.
                        state_d = STREAM;
                        valid_d = 1'b1;
                        index_d = order ? (occ_q - 4'd1) : 4'd0;
                        data_d  = taps[index_d];
                        last_d  = (occ_q == 4'd1);
                    end
                end
            end
            STREAM: begin
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (valid_q && out.out_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        index_d = next_index;
                        data_d  = snap_q[next_index];
                        last_d  = order_q ? (next_index == 4'd0)
                                          : (next_index == (snap_occ_q - 4'd1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            occ_q      <= 4'd0;
            snap_occ_q <= 4'd0;
            order_q    <= 1'b0;
            data_q     <= '0;
            index_q    <= 4'd0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            empty_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) snap_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            snap_occ_q <= snap_occ_d;
            order_q    <= order_d;
            data_q     <= data_d;
            index_q    <= index_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            empty_q    <= empty_d;
            if (snap_take) begin
                for (int i = 0; i < DEPTH; i++) snap_q[i] <= taps[i];
            end
        end
    end

    assign out.out_data  = data_q;
    assign out.out_index = index_q;
    assign out.out_valid = valid_q;
    assign out.out_last  = last_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign empty         = empty_q;
    assign occupancy     = occ_q;
endmodule

// File: doc/sns_readout.md
Name: sns_readout

Overview:
- Reader side of the shift-and-save history buffer: monitors the buffer's shift strobe and parallel value taps, and on request snapshots the history.
- Streams the snapshotted entries one per beat over a valid/ready interface, newest-first or oldest-first.
- Sits between the history buffer and the interrupt-handler readback path, so software or downstream logic can drain a consistent history while the buffer keeps shifting.

Parameters:
- DATA_WIDTH, 32, width of each history entry and of out_data.
- DEPTH, 10, number of history slots; fixed to match the 10 taps. Other values are unsupported.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- shift_en  input  1  the buffer's shift strobe; each high cycle means one new entry was written.
- value0..value9  input  DATA_WIDTH each  buffer taps; value0 is newest, value9 is oldest.
- start  input  1  one-cycle request to snapshot and stream; ignored while busy.
- order  input  1  sampled with start: 0 = newest-first, 1 = oldest-first.
- abort  input  1  terminates an active stream.
- out_data  output  DATA_WIDTH  current beat data.
- out_index  output  4  slot number (0..9) of the current beat.
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer ready.
- out_last  output  1  marks the final beat.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse when a stream completes, including an empty stream.
- empty  output  1  qualifies done: high when the snapshot held 0 entries.
- occupancy  output  4  live count of valid history entries, 0..10.

Behaviour:
- Reset: while reset is high at a rising edge, all state clears on that edge.
  - Outputs: out_data=0, out_index=0, out_valid=0, out_last=0, busy=0, done=0, empty=0, occupancy=0.
  - State returns to IDLE. Reset mid-stream discards the stream with no done pulse.
- Occupancy: increments on each shift_en edge and saturates at 10. Nothing else changes it except reset.
- State machine: IDLE, STREAM, DONE.
- IDLE: start=1 at edge N snapshots value0..value9 and the occupancy register as sampled at edge N (pre-increment if shift_en is also high), and latches order.
  - Snapshot occupancy > 0: go to STREAM. From cycle N+1, out_valid=1, busy=1, and the first beat is presented.
  - Snapshot occupancy = 0: go to DONE. In cycle N+1, done=1, empty=1, busy=1, out_valid stays 0.
- STREAM: beats cover snapshot slots in sequence.
  - Newest-first: slots 0,1,..,occ-1.
  - Oldest-first: slots occ-1 down to 0.
  - out_index carries the slot number; out_data is the snapshot of that slot.
  - A beat transfers on an edge with out_valid & out_ready. The next beat is presented in the following cycle, giving zero-bubble throughput at ready=1.
  - While out_ready=0, out_data, out_index and out_last hold stable.
  - out_last=1 only on the final beat.
  - Accepting the final beat moves the machine to DONE.
- DONE: lasts exactly one cycle with done=1 and busy=1. empty=1 only for a zero-entry snapshot. Then returns to IDLE.
- abort=1 in STREAM: next state is IDLE, out_valid and busy drop the next cycle, and no done pulse is issued. abort in IDLE or DONE has no effect.
- abort wins over a simultaneous final-beat handshake. The beat counts as transferred, but no done pulse is issued.
- start while busy is ignored (no queueing). start in the DONE cycle is also ignored.
- Writes during a stream (shift_en, changing taps) do not affect snapshot data. They still update occupancy.
- All outputs are registered. There is no combinational path from out_ready to out_valid.

Test Plan:
- Ordered drain: reset, shift in 0xA, 0xB, 0xC, start with order=0 and ready=1 -> beats 0xC/0, 0xB/1, 0xA/2 (data/index), out_last on the 3rd beat, done the next cycle, empty=0.
- Saturation with oldest-first: shift in 1..12 -> occupancy=10; start with order=1 -> beats 3..12 with out_index 9 down to 0, exactly 10 beats.
- Backpressure: during beat 2, drop out_ready for 3 cycles -> out_data, out_index and out_valid held unchanged, no beat lost or duplicated, total beat count correct.
- Empty buffer: start after reset -> done=1 and empty=1 in cycle N+1, out_valid never asserted; busy high 1 cycle.
- Concurrent shift: with 2 entries, assert start and shift_en (value 0x55) on the same edge, then keep shifting -> exactly 2 beats of the pre-shift data, and occupancy reads 3 and beyond during the stream.
- Abort and reset: abort after beat 1 of 5 -> out_valid low the next cycle, no done pulse, a new start is accepted. Repeat with reset instead of abort -> all outputs 0 and occupancy 0.
